// File: rtl/q_8_10_steer_ctrl.sv
// q_8_10_steer_ctrl: closed-loop x/y sequencer steering q_8_10_dff to a requested state
module q_8_10_steer_ctrl #(
  parameter int MAX_STEPS = 8,
  parameter int STEP_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_target,
  output logic              req_ready,
  input  logic [1:0]        state,
  output logic              x,
  output logic              y,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_ok,
  output logic [STEP_W-1:0] done_steps
);
  typedef enum logic [1:0] {IDLE, STEER, DONE} ctl_t;
  ctl_t              ctl;
  logic [1:0]        tgt_q;
  logic [STEP_W-1:0] steps_q;
  logic              ok_q;
  logic [1:0]        hold, hop;
  logic              at_tgt, timeout;
  always_comb begin
    hold    = state == 2'd2 ? 2'b10 : state == 2'd3 ? 2'b01 : 2'b00;
    hop     = state == 2'd0 ? 2'b10 :
              state == 2'd1 ? (tgt_q == 2'd3 ? 2'b01 : 2'b00) :
              state == 2'd2 ? (tgt_q == 2'd3 ? 2'b11 : 2'b00) :
                              (tgt_q == 2'd2 ? 2'b00 : 2'b11);
    at_tgt  = state == tgt_q;
    timeout = steps_q == STEP_W'(MAX_STEPS);
  end
  // x/y are forced low during reset so an aborted run never leaves the plant moving
  assign {x, y}     = rst ? 2'b00 : (ctl == STEER && !at_tgt && !timeout) ? hop : hold;
  assign req_ready  = !rst && ctl == IDLE;
  assign done_valid = ctl == DONE;
  assign done_ok    = done_valid & ok_q;
  assign done_steps = done_valid ? steps_q : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl     <= IDLE;
      tgt_q   <= 2'd0;
      steps_q <= '0;
      ok_q    <= 1'b0;
    end else begin
      case (ctl)
        IDLE: if (req_valid) begin
          tgt_q   <= req_target;
          steps_q <= '0;
          ok_q    <= 1'b0;
          ctl     <= STEER;
        end
        STEER: if (at_tgt || timeout) begin
          ok_q <= at_tgt;
          ctl  <= DONE;
        end else steps_q <= steps_q + STEP_W'(1);
        DONE: if (done_ready) ctl <= IDLE;
        default: ctl <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_q_8_10_steer_ctrl.sv
// tb_q_8_10_steer_ctrl: directed checks of the steering controller against a plant model
module tb_q_8_10_steer_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       req_ready;
  logic [1:0] state;
  logic       x, y;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       done_ok;
  logic [3:0] done_steps;
  logic [1:0] p_state;
  logic       force_en = 1'b0;
  logic [1:0] force_val = 2'd0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  q_8_10_steer_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .state(state), .x(x), .y(y), .done_valid(done_valid),
    .done_ready(done_ready), .done_ok(done_ok), .done_steps(done_steps)
  );

  function automatic logic [1:0] plant_next(input logic [1:0] s, input logic [1:0] xy);
    case (s)
      2'd0: plant_next = xy[1] ? 2'd1 : 2'd0;
      2'd1: plant_next = xy[0] ? 2'd3 : 2'd2;
      2'd2: plant_next = xy == 2'b00 ? 2'd0 : xy == 2'b11 ? 2'd3 : 2'd2;
      default: plant_next = xy == 2'b11 ? 2'd0 : xy == 2'b00 ? 2'd2 : 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_state <= 2'd0;
    else if (force_en) p_state <= force_val;
    else p_state <= plant_next(p_state, {x, y});
  end
  assign state = force_en ? force_val : p_state;

  task automatic test_reset;
    #3;
    if ({x, y} !== 2'b00) begin bad++; $display("FAIL rst_xy got=%b exp=00", {x, y}); end total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end total++;
    if (done_valid !== 1'b0) begin bad++; $display("FAIL rst_dv got=%b exp=0", done_valid); end total++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b exp=1", req_ready); end total++;
    @(negedge clk);
    if ({x, y} !== 2'b00) begin bad++; $display("FAIL rel_xy got=%b exp=00", {x, y}); end total++;
    if (state !== 2'd0) begin bad++; $display("FAIL rel_state got=%0d exp=0", state); end total++;
    if (done_ok !== 1'b0 || done_steps !== 4'd0) begin bad++; $display("FAIL rel_done got=%b/%0d exp=0/0", done_ok, done_steps); end total++;
  endtask

  task automatic test_path;
    req_valid = 1'b1; req_target = 2'd3;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL t2_ready got=%b exp=1", req_ready); end total++;
    @(negedge clk); req_valid = 1'b0;
    if ({x, y} !== 2'b10) begin bad++; $display("FAIL t2_hop0 got=%b exp=10", {x, y}); end total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL t2_busy got=%b exp=0", req_ready); end total++;
    @(negedge clk);
    if (state !== 2'd1 || {x, y} !== 2'b01) begin bad++; $display("FAIL t2_hop1 got=%0d/%b exp=1/01", state, {x, y}); end total++;
    @(negedge clk);
    if (state !== 2'd3 || done_valid !== 1'b0 || {x, y} !== 2'b01) begin bad++; $display("FAIL t2_arrive got=%0d/%b/%b exp=3/0/01", state, done_valid, {x, y}); end total++;
    @(negedge clk);
    if (done_valid !== 1'b1 || done_ok !== 1'b1 || done_steps !== 4'd2) begin bad++; $display("FAIL t2_done got=%b/%b/%0d exp=1/1/2", done_valid, done_ok, done_steps); end total++;
    if (state !== 2'd3) begin bad++; $display("FAIL t2_state got=%0d exp=3", state); end total++;
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
    if (done_valid !== 1'b0 || req_ready !== 1'b1 || done_steps !== 4'd0) begin bad++; $display("FAIL t2_idle got=%b/%b/%0d exp=0/1/0", done_valid, req_ready, done_steps); end total++;
  endtask

  task automatic test_same_target;
    req_valid = 1'b1; req_target = 2'd3;
    @(negedge clk); req_valid = 1'b0;
    if ({x, y} !== 2'b01 || done_valid !== 1'b0) begin bad++; $display("FAIL t3_steer got=%b/%b exp=01/0", {x, y}, done_valid); end total++;
    @(negedge clk);
    if (done_valid !== 1'b1 || done_ok !== 1'b1 || done_steps !== 4'd0) begin bad++; $display("FAIL t3_done got=%b/%b/%0d exp=1/1/0", done_valid, done_ok, done_steps); end total++;
    if ({x, y} !== 2'b01 || state !== 2'd3) begin bad++; $display("FAIL t3_hold got=%b/%0d exp=01/3", {x, y}, state); end total++;
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
    if (done_valid !== 1'b0) begin bad++; $display("FAIL t3_idle got=%b exp=0", done_valid); end total++;
  endtask

  task automatic test_timeout;
    force_en = 1'b1; force_val = 2'd2;
    req_valid = 1'b1; req_target = 2'd0;
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ({x, y} !== 2'b00 || done_valid !== 1'b0) begin bad++; $display("FAIL t4_step%0d got=%b/%b exp=00/0", i, {x, y}, done_valid); end total++;
      @(negedge clk);
    end
    if (done_valid !== 1'b0 || {x, y} !== 2'b10) begin bad++; $display("FAIL t4_limit got=%b/%b exp=0/10", done_valid, {x, y}); end total++;
    @(negedge clk);
    if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_steps !== 4'd8) begin bad++; $display("FAIL t4_done got=%b/%b/%0d exp=1/0/8", done_valid, done_ok, done_steps); end total++;
    done_ready = 1'b1; force_en = 1'b0;
    @(negedge clk); done_ready = 1'b0;
    if (done_valid !== 1'b0 || state !== 2'd2) begin bad++; $display("FAIL t4_idle got=%b/%0d exp=0/2", done_valid, state); end total++;
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_target = 2'd3;
    @(negedge clk); req_valid = 1'b0;
    if ({x, y} !== 2'b11) begin bad++; $display("FAIL t5_hop got=%b exp=11", {x, y}); end total++;
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_target = 2'd0;
    for (int i = 0; i < 5; i++) begin
      if (done_valid !== 1'b1 || done_ok !== 1'b1 || done_steps !== 4'd1 || req_ready !== 1'b0) begin
        bad++; $display("FAIL t5_stall%0d got=%b/%b/%0d/%b exp=1/1/1/0", i, done_valid, done_ok, done_steps, req_ready);
      end
      total++;
      @(negedge clk);
    end
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
    if (done_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL t5_release got=%b/%b exp=0/1", done_valid, req_ready); end total++;
    @(negedge clk); req_valid = 1'b0;
    if (req_ready !== 1'b0 || {x, y} !== 2'b11 || state !== 2'd3) begin bad++; $display("FAIL t5_accept got=%b/%b/%0d exp=0/11/3", req_ready, {x, y}, state); end total++;
    @(negedge clk);
    if (state !== 2'd0 || done_valid !== 1'b0) begin bad++; $display("FAIL t5_arrive got=%0d/%b exp=0/0", state, done_valid); end total++;
    @(negedge clk);
    if (done_valid !== 1'b1 || done_ok !== 1'b1 || done_steps !== 4'd1) begin bad++; $display("FAIL t5_done got=%b/%b/%0d exp=1/1/1", done_valid, done_ok, done_steps); end total++;
    done_ready = 1'b1;
    @(negedge clk); done_ready = 1'b0;
  endtask

  task automatic test_abort;
    req_valid = 1'b1; req_target = 2'd3;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    if ({x, y} !== 2'b01) begin bad++; $display("FAIL t6_pre got=%b exp=01", {x, y}); end total++;
    rst = 1'b1;
    #1;
    if ({x, y} !== 2'b00 || req_ready !== 1'b0 || done_valid !== 1'b0) begin bad++; $display("FAIL t6_abort got=%b/%b/%b exp=00/0/0", {x, y}, req_ready, done_valid); end total++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_valid !== 1'b0 || req_ready !== 1'b1 || {x, y} !== 2'b00 || state !== 2'd0) begin
        bad++; $display("FAIL t6_after%0d got=%b/%b/%b/%0d exp=0/1/00/0", i, done_valid, req_ready, {x, y}, state);
      end
      total++;
    end
  endtask

  initial begin
    test_reset;
    test_path;
    test_same_target;
    test_timeout;
    test_back_to_back;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
